// File: rtl/rcpu_intc.sv
// Interrupt controller for the RCPU core: merges up to 16 masked level/edge lines into a single
// irq/turnOffIRQ handshake with fixed lowest-index-first priority and per-channel vectors.
module rcpu_intc #(
    parameter int unsigned CHANNELS  = 8,
    parameter int unsigned N         = 32,
    parameter int unsigned M         = 16,
    parameter int unsigned VEC_SHIFT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] irqIn,
    output logic                irq,
    input  logic                turnOffIRQ,
    output logic [N-1:0]        intAddr,
    output logic [M-1:0]        intData,
    input  logic [2:0]          cfgAddr,
    input  logic [M-1:0]        cfgWrite,
    input  logic                cfgWE,
    input  logic                cfgRE,
    output logic [M-1:0]        cfgRead
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StReq    = 2'd1,
        StActive = 2'd2
    } state_e;

    localparam logic [2:0] AddrMask    = 3'd0;
    localparam logic [2:0] AddrEdge    = 3'd1;
    localparam logic [2:0] AddrPending = 3'd2;
    localparam logic [2:0] AddrVbaseLo = 3'd3;
    localparam logic [2:0] AddrVbaseHi = 3'd4;
    localparam logic [2:0] AddrEoi     = 3'd5;
    localparam logic [2:0] AddrStatus  = 3'd6;

    logic [CHANNELS-1:0] r_mask;
    logic [CHANNELS-1:0] r_edge;
    logic [CHANNELS-1:0] r_pend;
    logic [CHANNELS-1:0] r_prev;
    logic [31:0]         r_vbase;
    state_e              r_state;
    logic [3:0]          r_ch;
    logic                r_irq;
    logic [N-1:0]        r_addr;
    logic [M-1:0]        r_read;

    logic [15:0]         w_wr16;
    logic [CHANNELS-1:0] w_wr_ch;
    logic                w_we_pend;
    logic                w_eoi;
    logic                w_ack;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_clr;
    logic [CHANNELS-1:0] w_pend_d;
    logic [CHANNELS-1:0] w_req;
    logic                w_cand_valid;
    logic [3:0]          w_cand;
    logic [N-1:0]        w_vec;
    logic [M-1:0]        w_read;

    assign w_wr16    = 16'(cfgWrite);
    assign w_wr_ch   = CHANNELS'(cfgWrite);
    assign w_we_pend = cfgWE && (cfgAddr == AddrPending);
    assign w_eoi     = cfgWE && (cfgAddr == AddrEoi);
    assign w_ack     = (r_state == StReq) && turnOffIRQ;

    // Edge channels latch rising edges until acked or W1C'd (set beats clear);
    // level channels simply track the registered input.
    always_comb begin
        w_rise   = irqIn & ~r_prev;
        w_clr    = '0;
        w_pend_d = r_pend;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            w_clr[i] = (w_ack && (r_ch == 4'(i))) || (w_we_pend && w_wr_ch[i]);
            if (r_edge[i]) begin
                w_pend_d[i] = w_rise[i] | (r_pend[i] & ~w_clr[i]);
            end else begin
                w_pend_d[i] = irqIn[i];
            end
        end
    end

    // Fixed priority: scan downwards so the lowest index wins.
    always_comb begin
        w_req        = r_pend & r_mask;
        w_cand_valid = |w_req;
        w_cand       = '0;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_cand = 4'(i);
            end
        end
    end

    assign w_vec = N'(r_vbase) + (N'(w_cand) << VEC_SHIFT);

    always_comb begin
        w_read = '0;
        unique case (cfgAddr)
            AddrMask:    w_read = M'(r_mask);
            AddrEdge:    w_read = M'(r_edge);
            AddrPending: w_read = M'(r_pend);
            AddrVbaseLo: w_read = M'(r_vbase[15:0]);
            AddrVbaseHi: w_read = M'(r_vbase[31:16]);
            AddrStatus:  w_read = M'({r_state, r_ch});
            default:     w_read = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask  <= '0;
            r_edge  <= '0;
            r_pend  <= '0;
            r_prev  <= '0;
            r_vbase <= '0;
            r_read  <= '0;
        end else begin
            r_prev <= irqIn;
            r_pend <= w_pend_d;
            if (cfgWE) begin
                case (cfgAddr)
                    AddrMask:    r_mask <= w_wr_ch;
                    AddrEdge:    r_edge <= w_wr_ch;
                    AddrVbaseLo: r_vbase[15:0] <= w_wr16;
                    AddrVbaseHi: r_vbase[31:16] <= w_wr16;
                    default: ;
                endcase
            end
            // Read data is taken from pre-write register values.
            if (cfgRE) begin
                r_read <= w_read;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_ch    <= '0;
            r_irq   <= 1'b0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_cand_valid) begin
                        r_ch    <= w_cand;
                        r_addr  <= w_vec;
                        r_irq   <= 1'b1;
                        r_state <= StReq;
                    end
                end
                StReq: begin
                    // Request is committed: only the core's acknowledge retires it.
                    if (turnOffIRQ) begin
                        r_irq   <= 1'b0;
                        r_state <= StActive;
                    end
                end
                StActive: begin
                    if (w_eoi) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_irq   <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign irq     = r_irq;
    assign intAddr = r_addr;
    assign intData = M'(r_ch);
    assign cfgRead = r_read;

endmodule

// File: tb/tb_rcpu_intc.sv
// Directed bench for rcpu_intc: expectations are queued as stimulus is driven and
// popped against DUT outputs when they are observed.
module tb_rcpu_intc;

    localparam int unsigned CH = 8;
    localparam int unsigned N  = 32;
    localparam int unsigned M  = 16;
    localparam int unsigned VS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] irqIn;
    logic          irq;
    logic          turnOffIRQ;
    logic [N-1:0]  intAddr;
    logic [M-1:0]  intData;
    logic [2:0]    cfgAddr;
    logic [M-1:0]  cfgWrite;
    logic          cfgWE;
    logic          cfgRE;
    logic [M-1:0]  cfgRead;

    always #5 clk = ~clk;

    rcpu_intc #(
        .CHANNELS (CH),
        .N        (N),
        .M        (M),
        .VEC_SHIFT(VS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irqIn     (irqIn),
        .irq       (irq),
        .turnOffIRQ(turnOffIRQ),
        .intAddr   (intAddr),
        .intData   (intData),
        .cfgAddr   (cfgAddr),
        .cfgWrite  (cfgWrite),
        .cfgWE     (cfgWE),
        .cfgRE     (cfgRE),
        .cfgRead   (cfgRead)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic [15:0] rd;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_next(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL sb_empty: observed=%h required=<queued expectation>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: observed=%h required=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg_wr(input logic [2:0] a, input logic [15:0] d);
        cfgAddr  = a;
        cfgWrite = d;
        cfgWE    = 1'b1;
        @(negedge clk);
        cfgWE    = 1'b0;
    endtask

    task automatic cfg_rd(input logic [2:0] a, output logic [15:0] d);
        cfgAddr = a;
        cfgRE   = 1'b1;
        @(negedge clk);
        cfgRE   = 1'b0;
        d       = cfgRead;
    endtask

    // After return the rising edge has been sampled but the FSM has not yet captured.
    task automatic pulse(input logic [CH-1:0] m);
        irqIn = m;
        tick();
        irqIn = '0;
    endtask

    task automatic ack();
        turnOffIRQ = 1'b1;
        tick();
        turnOffIRQ = 1'b0;
    endtask

    task automatic expect_req(input string tag, input logic [31:0] addr, input logic [31:0] ch);
        expect_val({tag, "_irq"}, 32'd1);
        expect_val({tag, "_addr"}, addr);
        expect_val({tag, "_data"}, ch);
    endtask

    task automatic check_req();
        check_next(32'(irq));
        check_next(32'(intAddr));
        check_next(32'(intData));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        irqIn      = '0;
        turnOffIRQ = 1'b0;
        cfgAddr    = '0;
        cfgWrite   = '0;
        cfgWE      = 1'b0;
        cfgRE      = 1'b0;
        #1 rst = 1'b0;
        #2;
        expect_val("rst_irq", 0);     check_next(32'(irq));
        expect_val("rst_addr", 0);    check_next(32'(intAddr));
        expect_val("rst_data", 0);    check_next(32'(intData));
        expect_val("rst_cfgread", 0); check_next(32'(cfgRead));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        expect_val("rst_mask", 0);   cfg_rd(3'd0, rd); check_next(32'(rd));
        expect_val("rst_status", 0); cfg_rd(3'd6, rd); check_next(32'(rd));

        // Channel 3, edge mode, vector base 0x0001_0000
        cfg_wr(3'd1, 16'h0008);
        cfg_wr(3'd0, 16'h0008);
        cfg_wr(3'd3, 16'h0000);
        cfg_wr(3'd4, 16'h0001);
        expect_val("c3_lat_irq", 0);
        pulse(8'h08);
        check_next(32'(irq));
        expect_req("c3", 32'h0001_000C, 3);
        tick();
        check_req();
        expect_val("c3_status_req", 32'h13); cfg_rd(3'd6, rd); check_next(32'(rd));
        expect_val("c3_ack_irq", 0);
        ack();
        check_next(32'(irq));
        expect_val("c3_pend_ack", 0);        cfg_rd(3'd2, rd); check_next(32'(rd));
        expect_val("c3_status_act", 32'h23); cfg_rd(3'd6, rd); check_next(32'(rd));
        cfg_wr(3'd5, 16'h0000);
        expect_val("c3_status_idle", 32'h03); cfg_rd(3'd6, rd); check_next(32'(rd));
        expect_val("c3_idle_irq", 0); check_next(32'(irq));

        // Channels 2 and 5 together: lowest index first
        cfg_wr(3'd1, 16'h0024);
        cfg_wr(3'd0, 16'h0024);
        pulse(8'h24);
        expect_req("c2", 32'h0001_0008, 2);
        tick();
        check_req();
        ack();
        expect_val("c25_pend", 32'h20); cfg_rd(3'd2, rd); check_next(32'(rd));
        expect_val("c25_eoi_irq", 0);
        cfg_wr(3'd5, 16'h0000);
        check_next(32'(irq));
        expect_req("c5", 32'h0001_0014, 5);
        tick();
        check_req();
        ack();
        cfg_wr(3'd5, 16'h0000);

        // Channel 1 pending while masked, then unmasked
        cfg_wr(3'd0, 16'h0000);
        cfg_wr(3'd1, 16'h0002);
        pulse(8'h02);
        tick();
        expect_val("c1_masked_irq", 0); check_next(32'(irq));
        expect_val("c1_masked_pend", 32'h0002); cfg_rd(3'd2, rd); check_next(32'(rd));
        expect_val("c1_unmask_irq0", 0);
        cfg_wr(3'd0, 16'h0002);
        check_next(32'(irq));
        expect_req("c1", 32'h0001_0004, 1);
        tick();
        check_req();
        ack();
        expect_val("c1_pend_ack", 0); cfg_rd(3'd2, rd); check_next(32'(rd));
        cfg_wr(3'd5, 16'h0000);

        // Level channel 0 held high re-requests after EOI
        cfg_wr(3'd1, 16'h0000);
        cfg_wr(3'd0, 16'h0001);
        irqIn = 8'h01;
        tick();
        expect_val("l0_lat_irq", 0); check_next(32'(irq));
        expect_req("l0a", 32'h0001_0000, 0);
        tick();
        check_req();
        ack();
        expect_val("l0_eoi_irq", 0);
        cfg_wr(3'd5, 16'h0000);
        check_next(32'(irq));
        expect_req("l0b", 32'h0001_0000, 0);
        tick();
        check_req();
        ack();
        irqIn = '0;
        tick();
        tick();
        cfg_wr(3'd5, 16'h0000);
        tick();
        tick();
        expect_val("l0_drop_irq", 0); check_next(32'(irq));
        expect_val("l0_drop_status", 32'h00); cfg_rd(3'd6, rd); check_next(32'(rd));

        // Vector wrap with base 0xFFFF_FFFC
        cfg_wr(3'd3, 16'hFFFC);
        cfg_wr(3'd4, 16'hFFFF);
        cfg_wr(3'd1, 16'h0002);
        cfg_wr(3'd0, 16'h0002);
        pulse(8'h02);
        expect_req("wrap", 32'h0000_0000, 1);
        tick();
        check_req();
        expect_val("vbase_hi_rd", 32'hFFFF); cfg_rd(3'd4, rd); check_next(32'(rd));
        cfg_wr(3'd3, 16'h1234);
        expect_val("vbase_chg_addr", 0); check_next(32'(intAddr));
        ack();
        cfg_wr(3'd5, 16'h0000);

        // Reset while in REQ
        cfg_wr(3'd3, 16'h1000);
        cfg_wr(3'd4, 16'h0000);
        pulse(8'h02);
        expect_req("pre_rst", 32'h0000_1004, 1);
        tick();
        check_req();
        rst = 1'b0;
        #1;
        expect_val("async_rst_irq", 0);  check_next(32'(irq));
        expect_val("async_rst_addr", 0); check_next(32'(intAddr));
        @(negedge clk);
        rst = 1'b1;
        tick();
        expect_val("post_rst_status", 0); cfg_rd(3'd6, rd); check_next(32'(rd));
        expect_val("post_rst_mask", 0);   cfg_rd(3'd0, rd); check_next(32'(rd));
        expect_val("post_rst_irq", 0);    check_next(32'(irq));

        // W1C on an edge channel
        cfg_wr(3'd1, 16'h0002);
        pulse(8'h02);
        expect_val("w1c_before", 32'h0002); cfg_rd(3'd2, rd); check_next(32'(rd));
        cfg_wr(3'd2, 16'h0002);
        expect_val("w1c_after", 0); cfg_rd(3'd2, rd); check_next(32'(rd));
        expect_val("w1c_irq", 0); check_next(32'(irq));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
